// File: rtl/clock_ctrl.sv
// 24-hour time-of-day clock with RUN / SET_HOUR / SET_MIN modes driven by two buttons.
// Setting freezes time, blinks the edited field, and returns to RUN after an idle timeout.
module clock_ctrl #(
    parameter int SET_TIMEOUT = 30
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_mode,
    input  logic       i_inc,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic [1:0] o_state,
    output logic       o_blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(SET_TIMEOUT);

    state_t     r_state, w_state_next;
    logic [4:0] r_hour,  w_hour_next;
    logic [5:0] r_min,   w_min_next;
    logic [5:0] r_sec,   w_sec_next;
    logic [7:0] r_idle,  w_idle_next;
    logic       r_blink, w_blink_next;
    logic [7:0] w_idle_inc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_idle  <= '0;
            r_blink <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hour  <= w_hour_next;
            r_min   <= w_min_next;
            r_sec   <= w_sec_next;
            r_idle  <= w_idle_next;
            r_blink <= w_blink_next;
        end
    end

    // Buttons outrank the tick in set states: a coinciding tick neither counts nor toggles blink.
    always_comb begin
        w_state_next = r_state;
        w_hour_next  = r_hour;
        w_min_next   = r_min;
        w_sec_next   = r_sec;
        w_idle_next  = r_idle;
        w_blink_next = r_blink;
        w_idle_inc   = r_idle + 8'd1;

        case (r_state)
            RUN: begin
                w_idle_next  = '0;
                w_blink_next = 1'b0;
                if (i_tick) begin
                    if (r_sec == 6'd59) begin
                        w_sec_next = '0;
                        if (r_min == 6'd59) begin
                            w_min_next  = '0;
                            w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                        end else begin
                            w_min_next = r_min + 6'd1;
                        end
                    end else begin
                        w_sec_next = r_sec + 6'd1;
                    end
                end
                if (i_mode) begin
                    w_state_next = SET_HOUR;
                    w_blink_next = 1'b1;
                end
            end

            SET_HOUR, SET_MIN: begin
                if (i_mode) begin
                    w_idle_next = '0;
                    if (r_state == SET_HOUR) begin
                        w_state_next = SET_MIN;
                        w_blink_next = 1'b1;
                    end else begin
                        w_state_next = RUN;
                        w_sec_next   = '0;
                        w_blink_next = 1'b0;
                    end
                end else if (i_inc) begin
                    w_idle_next  = '0;
                    w_blink_next = 1'b1;
                    if (r_state == SET_HOUR) begin
                        w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        w_min_next = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                    end
                end else if (i_tick) begin
                    if (w_idle_inc == TIMEOUT_CNT) begin
                        w_state_next = RUN;
                        w_sec_next   = '0;
                        w_idle_next  = '0;
                        w_blink_next = 1'b0;
                    end else begin
                        w_idle_next  = w_idle_inc;
                        w_blink_next = ~r_blink;
                    end
                end
            end

            default: begin
                w_state_next = RUN;
                w_idle_next  = '0;
                w_blink_next = 1'b0;
            end
        endcase
    end

    assign o_hour  = r_hour;
    assign o_min   = r_min;
    assign o_sec   = r_sec;
    assign o_state = r_state;
    assign o_blink = r_blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a short-timeout instance for most scenarios,
// and a default-timeout instance for the blink sequence that needs more than 3 idle ticks.
module tb_clock_ctrl;

    typedef struct {
        bit    sel;
        int    hour;
        int    min;
        int    sec;
        int    state;
        int    blink;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic aTick = 1'b0, aMode = 1'b0, aInc = 1'b0;
    logic bTick = 1'b0, bMode = 1'b0, bInc = 1'b0;
    logic [4:0] aHour, bHour;
    logic [5:0] aMin, aSec, bMin, bSec;
    logic [1:0] aState, bState;
    logic       aBlink, bBlink;

    int   errors = 0;
    int   checks = 0;
    exp_t scoreQ[$];

    always #5 clk = ~clk;

    clock_ctrl #(.SET_TIMEOUT(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_tick(aTick), .i_mode(aMode), .i_inc(aInc),
        .o_hour(aHour), .o_min(aMin), .o_sec(aSec), .o_state(aState), .o_blink(aBlink)
    );

    clock_ctrl #(.SET_TIMEOUT(30)) dutLong (
        .i_clk(clk), .i_reset(reset), .i_tick(bTick), .i_mode(bMode), .i_inc(bInc),
        .o_hour(bHour), .o_min(bMin), .o_sec(bSec), .o_state(bState), .o_blink(bBlink)
    );

    // Drive one cycle of inputs on the falling edge and queue what the outputs must show after the next rising edge.
    task automatic applyStimulus(input bit sel, input bit rst, input bit tk, input bit md, input bit ic,
                                 input int h, input int m, input int s, input int st, input int bl,
                                 input string name);
        exp_t e;
        @(negedge clk);
        reset = rst;
        aTick = sel ? 1'b0 : tk;
        aMode = sel ? 1'b0 : md;
        aInc  = sel ? 1'b0 : ic;
        bTick = sel ? tk : 1'b0;
        bMode = sel ? md : 1'b0;
        bInc  = sel ? ic : 1'b0;
        e.sel = sel; e.hour = h; e.min = m; e.sec = s; e.state = st; e.blink = bl; e.name = name;
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        int h, m, s, st, bl;
        h  = e.sel ? int'(bHour)  : int'(aHour);
        m  = e.sel ? int'(bMin)   : int'(aMin);
        s  = e.sel ? int'(bSec)   : int'(aSec);
        st = e.sel ? int'(bState) : int'(aState);
        bl = e.sel ? int'(bBlink) : int'(aBlink);
        checks++;
        if (h !== e.hour || m !== e.min || s !== e.sec || st !== e.state || bl !== e.blink) begin
            errors++;
            $display("[TB] FAIL %s: got %0d:%0d:%0d state=%0d blink=%0d, expected %0d:%0d:%0d state=%0d blink=%0d",
                     e.name, h, m, s, st, bl, e.hour, e.min, e.sec, e.state, e.blink);
        end
    endtask

    // Monitor: outputs settle just after each rising edge; one queued expectation per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
        end
    end

    initial begin
        // Reset, with buttons held high during the second reset cycle
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        applyStimulus(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, "resetIgnoresInputs");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, "firstTick");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, "incIgnoredInRun");

        // Reach 10:20:33 in RUN
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, "enterSetHour");
        for (int k = 1; k <= 10; k++) applyStimulus(0, 0, 0, 0, 1, k, 0, 1, 1, 1, "incHour");
        applyStimulus(0, 0, 0, 1, 0, 10, 0, 1, 2, 1, "enterSetMin");
        for (int k = 1; k <= 20; k++) applyStimulus(0, 0, 0, 0, 1, 10, k, 1, 2, 1, "incMin");
        applyStimulus(0, 0, 0, 1, 0, 10, 20, 0, 0, 0, "exitSetMinClearsSec");
        for (int k = 1; k <= 33; k++) applyStimulus(0, 0, 1, 0, 0, 10, 20, k, 0, 0, "runTick");

        // Set sequence: 15 hour incs wrap 23->0, 45 min incs wrap 59->0
        applyStimulus(0, 0, 0, 1, 0, 10, 20, 33, 1, 1, "setSeqHour");
        for (int k = 1; k <= 15; k++) applyStimulus(0, 0, 0, 0, 1, (10 + k) % 24, 20, 33, 1, 1, "setSeqIncHour");
        applyStimulus(0, 0, 0, 1, 0, 1, 20, 33, 2, 1, "setSeqMin");
        for (int k = 1; k <= 45; k++) applyStimulus(0, 0, 0, 0, 1, 1, (20 + k) % 60, 33, 2, 1, "setSeqIncMin");
        applyStimulus(0, 0, 0, 1, 0, 1, 5, 0, 0, 0, "setSeqDone");

        // mode+inc collision in SET_HOUR
        applyStimulus(0, 0, 0, 1, 0, 1, 5, 0, 1, 1, "collideEnter");
        applyStimulus(0, 0, 0, 0, 1, 2, 5, 0, 1, 1, "collideInc");
        applyStimulus(0, 0, 0, 1, 1, 2, 5, 0, 2, 1, "modeIncCollide");
        applyStimulus(0, 0, 0, 1, 0, 2, 5, 0, 0, 0, "collideExit");

        // Bring time to 00:00:59, then tick+mode in RUN
        applyStimulus(0, 0, 0, 1, 0, 2, 5, 0, 1, 1, "zeroEnter");
        for (int k = 1; k <= 22; k++) applyStimulus(0, 0, 0, 0, 1, (2 + k) % 24, 5, 0, 1, 1, "zeroHour");
        applyStimulus(0, 0, 0, 1, 0, 0, 5, 0, 2, 1, "zeroMinEnter");
        for (int k = 1; k <= 55; k++) applyStimulus(0, 0, 0, 0, 1, 0, (5 + k) % 60, 0, 2, 1, "zeroMin");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "zeroExit");
        for (int k = 1; k <= 59; k++) applyStimulus(0, 0, 1, 0, 0, 0, 0, k, 0, 0, "tickTo59");
        applyStimulus(0, 0, 1, 1, 0, 0, 1, 0, 1, 1, "tickModeCollide");

        // Timeout in SET_MIN (SET_TIMEOUT=3), time frozen while ticking
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 2, 1, "toEnterMin");
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 2, 0, "frozenTick1");
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 2, 1, "frozenTick2");
        applyStimulus(0, 0, 0, 0, 1, 0, 2, 0, 2, 1, "toIncClearsIdle");
        applyStimulus(0, 0, 1, 0, 0, 0, 2, 0, 2, 0, "toTick1");
        applyStimulus(0, 0, 1, 0, 0, 0, 2, 0, 2, 1, "toTick2");
        applyStimulus(0, 0, 1, 0, 0, 0, 2, 0, 0, 0, "timeoutMin");

        // Rollover: preload 23:59:58 and tick through midnight
        applyStimulus(0, 0, 0, 1, 0, 0, 2, 0, 1, 1, "rollEnter");
        for (int k = 1; k <= 23; k++) applyStimulus(0, 0, 0, 0, 1, k, 2, 0, 1, 1, "rollHour");
        applyStimulus(0, 0, 0, 1, 0, 23, 2, 0, 2, 1, "rollMinEnter");
        for (int k = 1; k <= 57; k++) applyStimulus(0, 0, 0, 0, 1, 23, 2 + k, 0, 2, 1, "rollMin");
        applyStimulus(0, 0, 0, 1, 0, 23, 59, 0, 0, 0, "rollExit");
        for (int k = 1; k <= 58; k++) applyStimulus(0, 0, 1, 0, 0, 23, 59, k, 0, 0, "rollTick");
        applyStimulus(0, 0, 1, 0, 0, 23, 59, 59, 0, 0, "at235959");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "midnightWrap");

        // Reset mid SET_MIN with all buttons high
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, "midEnterHour");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 2, 1, "midEnterMin");
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 2, 1, "midIncMin");
        applyStimulus(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, "resetMidSet");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, "tickAfterReset");

        // tick+inc in SET_HOUR: tick not counted, then timeout from SET_HOUR
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, "thEnter");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, "thTick1");
        applyStimulus(0, 0, 1, 0, 1, 1, 0, 1, 1, 1, "tickIncCollide");
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, "thTick2");
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 1, 1, 1, "thTick3");
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, "timeoutHour");

        // Blink on the long-timeout instance
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, "blinkEnter");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "blinkTick1");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, "blinkTick2");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "blinkTick3");
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 1, 1, "blinkIncForces");
        applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 2, 1, "blinkEnterMin");
        applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, "blinkExit");
        for (int k = 1; k <= 100; k++) applyStimulus(1, 0, 1, 0, 0, 1, k / 60, k % 60, 0, 0, "runBlinkOff");

        @(negedge clk);
        aTick = 1'b0; aMode = 1'b0; aInc = 1'b0;
        bTick = 1'b0; bMode = 1'b0; bInc = 1'b0;

        for (int i = 0; i < 10 && scoreQ.size() > 0; i++) @(posedge clk);
        #3;
        if (scoreQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", scoreQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
